// File: rtl/pulse_gate_counter.sv
// Gated pulse counter: counts detector pulses over GATE_TICKS edges of the 5 ms
// timebase and hands each finished gate count to the reader with a valid/ack pair.
module pulse_gate_counter #(
  parameter int unsigned GATE_TICKS = 200,
  parameter int unsigned CNT_WIDTH  = 24
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clk_5ms,
  input  logic                 pulse_in,
  input  logic                 rd_ack,
  output logic [CNT_WIDTH-1:0] count_out,
  output logic                 count_valid,
  output logic                 overflow,
  output logic                 data_lost,
  output logic                 busy,
  output logic                 state_dbg
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_e;

  localparam logic [15:0]          LAST_TICK = 16'(GATE_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [2:0]           tb_sync_q, pl_sync_q;
  logic                 tick, pulse_evt, gate_close;
  logic [CNT_WIDTH-1:0] acc_q, acc_d, acc_evt;
  logic                 sat_q, sat_d, sat_evt;
  logic [15:0]          tick_cnt_q, tick_cnt_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic                 lost_q, lost_d;

  // Two flops resynchronise, the third gives the previous level for edge detection.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      tb_sync_q <= '0;
      pl_sync_q <= '0;
    end else begin
      tb_sync_q <= {tb_sync_q[1:0], clk_5ms};
      pl_sync_q <= {pl_sync_q[1:0], pulse_in};
    end
  end

  assign tick      = tb_sync_q[1] ^ tb_sync_q[2];
  assign pulse_evt = pl_sync_q[1] & ~pl_sync_q[2];

  // FSM: state register
  always_ff @(posedge clk_in) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable && tick) state_d = S_COUNT;
      S_COUNT: if (!enable)        state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state_q == S_COUNT);
    state_dbg = state_q;
  end

  assign gate_close = (state_q == S_COUNT) && enable && tick && (tick_cnt_q == LAST_TICK);

  // A pulse arriving with the closing tick belongs to the gate being closed.
  always_comb begin
    acc_evt = acc_q;
    if (pulse_evt && !(&acc_q)) acc_evt = acc_q + CNT_ONE;
    sat_evt = sat_q | (&acc_evt);
  end

  // Handshake: count_valid rises when a gate is latched and stays high until a
  // cycle with rd_ack=1; rd_ack while count_valid=0 has no effect, and a latch
  // in the same cycle as rd_ack wins, leaving count_valid high with fresh data.
  always_comb begin
    acc_d      = acc_q;
    sat_d      = sat_q;
    tick_cnt_d = tick_cnt_q;
    count_d    = count_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    lost_d     = lost_q;
    if (rd_ack && valid_q) valid_d = 1'b0;
    if (state_q == S_COUNT && enable) begin
      acc_d = acc_evt;
      sat_d = sat_evt;
      if (tick) tick_cnt_d = tick_cnt_q + 16'd1;
      if (gate_close) begin
        count_d    = acc_evt;
        ovf_d      = sat_evt;
        valid_d    = 1'b1;
        if (valid_q && !rd_ack) lost_d = 1'b1;
        acc_d      = '0;
        sat_d      = 1'b0;
        tick_cnt_d = '0;
      end
    end else begin
      acc_d      = '0;
      sat_d      = 1'b0;
      tick_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      acc_q      <= '0;
      sat_q      <= 1'b0;
      tick_cnt_q <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      tick_cnt_q <= tick_cnt_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      lost_q     <= lost_d;
    end
  end

  assign count_out   = count_q;
  assign count_valid = valid_q;
  assign overflow    = ovf_q;
  assign data_lost   = lost_q;

endmodule

// File: tb/tb_pulse_gate_counter.sv
// Bench for pulse_gate_counter: directed gate scenarios plus random pulse traffic,
// checked by a tick-level reference model feeding an expected-latch queue.
module tb_pulse_gate_counter;

  localparam int W    = 8;
  localparam int G    = 4;
  localparam int MAXC = (1 << W) - 1;

  logic         clk_in = 1'b0;
  logic         reset, enable, clk_5ms, pulse_in, rd_ack;
  logic [W-1:0] count_out;
  logic         count_valid, overflow, data_lost, busy, state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  // expected latch: {count, overflow, data_lost}
  logic [W+1:0] exp_q[$];

  // reference model state, advanced once per timebase edge
  bit m_counting = 0;
  bit m_valid    = 0;
  bit m_lost     = 0;
  int m_sum      = 0;
  int m_ticks    = 0;

  pulse_gate_counter #(.GATE_TICKS(G), .CNT_WIDTH(W)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .enable      (enable),
    .clk_5ms     (clk_5ms),
    .pulse_in    (pulse_in),
    .rd_ack      (rd_ack),
    .count_out   (count_out),
    .count_valid (count_valid),
    .overflow    (overflow),
    .data_lost   (data_lost),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  always #5 clk_in = ~clk_in;

  task automatic ck(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One timebase half-period: edge on clk_5ms at cycle 0, then n pulses
  // (rising at cycles 2,4,...). coin adds a pulse edge together with the tick
  // edge; ack_at>=0 raises rd_ack for that one cycle (2 = same cycle as a close).
  task automatic run_interval(input int n, input int len, input int ack_at, input bit coin);
    logic closing;
    int   cnt;
    @(posedge clk_in); #1;
    clk_5ms  = ~clk_5ms;
    pulse_in = coin;
    rd_ack   = 1'b0;
    closing  = 1'b0;
    if (m_counting) begin
      m_sum += int'(coin);
      m_ticks++;
      if (m_ticks == G) begin
        closing = 1'b1;
        cnt = (m_sum >= MAXC) ? MAXC : m_sum;
        if (m_valid && ack_at != 2) m_lost = 1;
        m_valid = 1;
        exp_q.push_back({cnt[W-1:0], (m_sum >= MAXC), m_lost});
        m_sum   = 0;
        m_ticks = 0;
      end
    end else if (enable) begin
      m_counting = 1;
      m_sum      = 0;
      m_ticks    = 0;
    end
    if (ack_at >= 0 && !(ack_at == 2 && closing)) m_valid = 0;
    if (m_counting) m_sum += n;
    for (int c = 1; c < len; c++) begin
      @(posedge clk_in); #1;
      if (c == 1) pulse_in = 1'b0;
      if (c >= 2 && c <= 2 * n + 1) pulse_in = (c % 2 == 0);
      rd_ack = (c == ack_at);
      if (c == len - 2) begin
        ck("busy", busy, m_counting);
        ck("state_dbg", state_dbg, m_counting);
        ck("count_valid", count_valid, m_valid);
        ck("data_lost", data_lost, m_lost);
      end
    end
  endtask

  // Monitor: a latch shows up as count_valid rising or latched fields changing.
  initial begin
    logic [W-1:0] p_cnt;
    logic         p_v, p_o, p_l;
    logic [W+1:0] exp;
    p_cnt = '0; p_v = 1'b0; p_o = 1'b0; p_l = 1'b0;
    forever begin
      @(negedge clk_in);
      if (count_valid === 1'b1 &&
          (!p_v || count_out !== p_cnt || overflow !== p_o || data_lost !== p_l)) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_latch: got cnt=%0d ovf=%0b lost=%0b, none expected (t=%0t)",
                   count_out, overflow, data_lost, $time);
        end else begin
          exp = exp_q.pop_front();
          if ({count_out, overflow, data_lost} !== exp) begin
            n_bad++;
            $display("FAIL latch: got cnt=%0d ovf=%0b lost=%0b, expected cnt=%0d ovf=%0b lost=%0b (t=%0t)",
                     count_out, overflow, data_lost, exp[W+1:2], exp[1], exp[0], $time);
          end
        end
      end
      p_cnt = count_out; p_v = count_valid; p_o = overflow; p_l = data_lost;
    end
  end

  task automatic ck_all_zero(input string tag);
    ck({tag, "_count_out"}, count_out, 0);
    ck({tag, "_count_valid"}, count_valid, 0);
    ck({tag, "_overflow"}, overflow, 0);
    ck({tag, "_data_lost"}, data_lost, 0);
    ck({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clk_5ms = 1'b0; pulse_in = 1'b0; rd_ack = 1'b0;
    repeat (5) @(posedge clk_in);
    @(negedge clk_in);
    ck_all_zero("in_reset");
    #1 reset = 1'b0;
    @(negedge clk_in);
    ck_all_zero("after_reset");

    enable = 1'b1;
    repeat (4) run_interval(10, 60, -1, 0);
    run_interval(6, 60, -1, 0);
    ck("gate1_count", count_out, 40);
    ck("gate1_ovf", overflow, 0);
    ck("gate1_valid", count_valid, 1);
    repeat (3) run_interval(6, 60, -1, 0);

    // rd_ack coincident with the close while unread data is pending
    run_interval(5, 60, 2, 0);
    ck("ack_close_count", count_out, 24);
    ck("ack_close_valid", count_valid, 1);
    ck("ack_close_lost", data_lost, 0);
    run_interval(5, 60, 10, 0);
    ck("ack_clears_valid", count_valid, 0);
    repeat (2) run_interval(5, 60, -1, 0);

    // two gates without reading
    run_interval(5, 60, -1, 0);
    ck("noack1_count", count_out, 20);
    ck("noack1_lost", data_lost, 0);
    repeat (3) run_interval(5, 60, -1, 0);
    run_interval(100, 220, 10, 0);
    ck("noack2_count", count_out, 20);
    ck("noack2_lost", data_lost, 1);
    ck("noack2_valid_after_ack", count_valid, 0);

    // saturation, then recovery
    repeat (3) run_interval(100, 220, -1, 0);
    run_interval(1, 60, 10, 0);
    ck("sat_count", count_out, MAXC);
    ck("sat_ovf", overflow, 1);
    repeat (3) run_interval(1, 60, -1, 0);
    run_interval(10, 60, 10, 0);
    ck("post_sat_count", count_out, 4);
    ck("post_sat_ovf", overflow, 0);

    // pulse coincident with the closing tick
    repeat (3) run_interval(10, 60, -1, 0);
    run_interval(3, 60, 10, 1);
    ck("coin_count", count_out, 41);
    repeat (3) run_interval(3, 60, -1, 0);
    run_interval(2, 60, 10, 0);
    ck("after_coin_count", count_out, 12);
    repeat (3) run_interval(2, 60, -1, 0);

    // random traffic, each gate read early in the following gate
    repeat (8) begin
      run_interval($urandom_range(28, 0), 60, $urandom_range(50, 5), 1'($urandom_range(1, 0)));
      repeat (3) run_interval($urandom_range(28, 0), 60, -1, 1'($urandom_range(1, 0)));
    end
    run_interval($urandom_range(28, 0), 60, $urandom_range(50, 5), 1'b0);
    repeat (2) run_interval(4, 60, -1, 0);

    // drop enable two ticks into a gate
    repeat (20) @(posedge clk_in);
    #1 enable = 1'b0;
    m_counting = 0;
    m_sum = 0;
    @(posedge clk_in);
    @(negedge clk_in);
    ck("disable_busy", busy, 0);
    repeat (2) run_interval(5, 60, -1, 0);
    repeat (10) @(posedge clk_in);
    #1 enable = 1'b1;
    repeat (2) run_interval(5, 60, -1, 0);

    // reset mid-gate
    repeat (20) @(posedge clk_in);
    #1 reset = 1'b1;
    @(posedge clk_in);
    #1 reset = 1'b0; enable = 1'b0;
    m_counting = 0; m_valid = 0; m_lost = 0; m_sum = 0; m_ticks = 0;
    @(negedge clk_in);
    ck_all_zero("mid_reset");
    repeat (20) @(posedge clk_in);
    @(negedge clk_in);
    ck_all_zero("post_reset");
    ck("pending_latches", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
